frame_read_server: RTL and testbench

- Responder side of the frame read interface: read_req/read_req_ack, read_en/read_data.
- On each read_req it restarts the frame at BASE_ADDR and prefetches fixed-length bursts from a memory read port into an internal FIFO.
- It pops one word per read_en, so the display timing block always has pixel data ready.
- Sits between the frame-buffer memory controller and the video timing/data generator; everything runs in the pixel clock domain.

---
 rtl/frame_read_server_if.sv | 49 ++++
 rtl/frame_read_server.sv | 200 ++++++++++++++++++++
 tb/tb_frame_read_server.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_read_server_if.sv
// frame_read_server_if: bundles the frame read handshake (requester side)
// and the burst read port of the frame-buffer memory.
//   read_req / read_req_ack : frame start request and one-cycle acknowledge
//   read_en / read_data     : word pop and popped word
//   mem_rd_*                : burst request/ack/address plus read beats
//   frame_busy / underflow  : frame status
//   underflow_cnt           : present only with FRAME_READ_UNDERFLOW_CNT_EN
// Modports: slave = frame_read_server, master = requester plus memory.
interface frame_read_server_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  read_req;
  logic                  read_req_ack;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_rd_req;
  logic                  mem_rd_ack;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_valid;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  frame_busy;
  logic                  underflow;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  logic [15:0]           underflow_cnt;

  modport slave (
    input  read_req, read_en, mem_rd_ack, mem_rd_valid, mem_rd_data,
    output read_req_ack, read_data, mem_rd_req, mem_rd_addr,
           frame_busy, underflow, underflow_cnt
  );
  modport master (
    output read_req, read_en, mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  read_req_ack, read_data, mem_rd_req, mem_rd_addr,
           frame_busy, underflow, underflow_cnt
  );
`else
  modport slave (
    input  read_req, read_en, mem_rd_ack, mem_rd_valid, mem_rd_data,
    output read_req_ack, read_data, mem_rd_req, mem_rd_addr,
           frame_busy, underflow
  );
  modport master (
    output read_req, read_en, mem_rd_ack, mem_rd_valid, mem_rd_data,
    input  read_req_ack, read_data, mem_rd_req, mem_rd_addr,
           frame_busy, underflow
  );
`endif
endinterface

// File: rtl/frame_read_server.sv
// frame_read_server: responder for the frame read interface. Each accepted
// read_req restarts the frame at BASE_ADDR and prefetches BURST_LEN-word
// bursts into a FIFO_DEPTH-word FIFO; one word is popped per read_en.
// Ports:
//   video_clk : pixel clock (sole clock domain)
//   rst_n     : asynchronous active-low reset
//   bus       : frame_read_server_if.slave (read handshake, memory burst
//               port, frame_busy, underflow[, underflow_cnt])
// Optional: define FRAME_READ_UNDERFLOW_CNT_EN to add the saturating
// per-frame underflow_cnt output.
module frame_read_server #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 24,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           FRAME_WORDS = 786432,
  parameter int unsigned           BURST_LEN   = 64,
  parameter int unsigned           FIFO_DEPTH  = 256
) (
  input logic                video_clk,
  input logic                rst_n,
  frame_read_server_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BW = $clog2(BURST_LEN) + 1;

  localparam logic [CW-1:0]         FREE_LIMIT = CW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0]         FRAME_C    = IW'(FRAME_WORDS);
  localparam logic [IW-1:0]         BURST_IW   = IW'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BURST_AW   = ADDR_WIDTH'(BURST_LEN);
  localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, ACK, CHECK, REQ, DATA} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ack_q, ack_d, req_q, req_d, busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IW-1:0]         issued_q, issued_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  uf_q, uf_d, pend_q, pend_d, armed_q, armed_d;
  logic                  wr_en, pop_ok, trigger;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  logic [15:0]           ucnt_q, ucnt_d;
`endif

  // A request only counts once read_req has been seen low since the last ack,
  // so a requester still holding read_req after its ack does not re-trigger.
  assign trigger = bus.read_req && armed_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    issued_d  = issued_q;
    beat_d    = beat_q;
    uf_d      = uf_q;
    pend_d    = pend_q;
    armed_d   = armed_q;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    ucnt_d    = ucnt_q;
`endif
    wr_en     = 1'b0;
    pop_ok    = 1'b0;

    if (!bus.read_req) armed_d = 1'b1;

    unique case (state_q)
      IDLE: if (trigger) state_d = ACK;
      ACK: begin
        armed_d  = 1'b0;
        pend_d   = 1'b0;
        addr_d   = BASE_ADDR;
        issued_d = '0;
        state_d  = CHECK;
      end
      CHECK: begin
        if (pend_q || trigger)        state_d = ACK;
        else if (issued_q == FRAME_C) state_d = IDLE;
        else if (count_q <= FREE_LIMIT) state_d = REQ;
      end
      REQ: begin
        if (trigger) pend_d = 1'b1;
        if (bus.mem_rd_ack) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (trigger) pend_d = 1'b1;
        if (bus.mem_rd_valid) begin
          // Beats of a burst cut short by a restart are counted, not stored.
          wr_en = !pend_q && (count_q != DEPTH_C);
          if (beat_q == LAST_BEAT) begin
            addr_d   = addr_q + BURST_AW;
            issued_d = issued_q + BURST_IW;
            state_d  = CHECK;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // No bypass: an empty-FIFO pop underflows even if a beat lands this cycle.
    if (bus.read_en) begin
      if (count_q != '0) begin
        pop_ok    = 1'b1;
        rd_data_d = fifo_mem[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + PW'(1);
      end else begin
        rd_data_d = '0;
        uf_d      = 1'b1;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
        if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
`endif
      end
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (wr_en && !pop_ok)      count_d = count_q + CW'(1);
    else if (!wr_en && pop_ok) count_d = count_q - CW'(1);

    if (state_q == ACK) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      uf_d     = 1'b0;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      ucnt_d   = '0;
`endif
    end

    ack_d  = (state_d == ACK);
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= BASE_ADDR;
      issued_q  <= '0;
      beat_q    <= '0;
      uf_q      <= 1'b0;
      pend_q    <= 1'b0;
      armed_q   <= 1'b1;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      ucnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      issued_q  <= issued_d;
      beat_q    <= beat_d;
      uf_q      <= uf_d;
      pend_q    <= pend_d;
      armed_q   <= armed_d;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      ucnt_q    <= ucnt_d;
`endif
    end
  end

  always_ff @(posedge video_clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= bus.mem_rd_data;
  end

  assign bus.read_req_ack = ack_q;
  assign bus.read_data    = rd_data_q;
  assign bus.mem_rd_req   = req_q;
  assign bus.mem_rd_addr  = addr_q;
  assign bus.frame_busy   = busy_q;
  assign bus.underflow    = uf_q;
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
  assign bus.underflow_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_frame_read_server.sv
module tb_frame_read_server;
  localparam logic [23:0] BASE = 24'h001000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frame_read_server_if #(.DATA_WIDTH(16), .ADDR_WIDTH(24)) bus ();

  frame_read_server #(
    .DATA_WIDTH(16), .ADDR_WIDTH(24), .BASE_ADDR(BASE),
    .FRAME_WORDS(256), .BURST_LEN(16), .FIFO_DEPTH(64)
  ) dut (
    .video_clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  int ack_total = 0;
  int gap_max = 0;
  int ackd_max = 0;
  logic [23:0] burst_log[$];
  logic [23:0] cur_addr;
  int beats_this_burst;
  bit in_burst;
  bit hit5;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) if (bus.read_req_ack === 1'b1) ack_total++;

  // Memory model: answers each burst request after a random delay, then
  // returns 16 beats (data = word address) with random gaps.
  initial begin
    int d, g;
    bus.mem_rd_ack = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    in_burst = 1'b0; hit5 = 1'b0; beats_this_burst = 0; cur_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.mem_rd_req === 1'b1) begin
        d = $urandom_range(ackd_max, 0);
        repeat (d) @(negedge clk);
        bus.mem_rd_ack = 1'b1;
        cur_addr = bus.mem_rd_addr;
        burst_log.push_back(cur_addr);
        beats_this_burst = 0;
        in_burst = 1'b1;
        @(negedge clk);
        bus.mem_rd_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
          g = $urandom_range(gap_max, 0);
          repeat (g) @(negedge clk);
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data = 16'(cur_addr + 24'(i));
          beats_this_burst = i + 1;
          hit5 = (cur_addr == 24'h001020) && (i == 4);
          @(negedge clk);
          bus.mem_rd_valid = 1'b0;
          hit5 = 1'b0;
        end
        in_burst = 1'b0;
      end
    end
  end

  task automatic wait_ack(input int lim);
    bit seen = 1'b0;
    for (int c = 0; c < lim && !seen; c++) begin
      @(negedge clk);
      seen = (bus.read_req_ack === 1'b1);
    end
    check("ack_seen", 32'(seen), 32'd1);
    bus.read_req = 1'b0;
  endtask

  task automatic do_req();
    bus.read_req = 1'b1;
    wait_ack(200);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    for (int c = 0; c < lim && bus.frame_busy !== 1'b0; c++) @(negedge clk);
    check("frame_idle", 32'(bus.frame_busy), 32'd0);
  endtask

  task automatic pop_empty(input string name);
    bus.read_en = 1'b1;
    @(posedge clk); #1;
    check({name, "_data"}, 32'(bus.read_data), 32'd0);
    check({name, "_flag"}, 32'(bus.underflow), 32'd1);
    @(negedge clk);
    bus.read_en = 1'b0;
  endtask

  initial begin
    int b0, a0, popped, cnt, exp_ucnt;
    logic [15:0] exp_rd;
    bit exp_uf, re, wr, found;

    rst_n = 1'b0; bus.read_req = 1'b0; bus.read_en = 1'b0;
    gap_max = 2; ackd_max = 2;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.read_req_ack), 32'd0);
    check("rst_data", 32'(bus.read_data), 32'd0);
    check("rst_memreq", 32'(bus.mem_rd_req), 32'd0);
    check("rst_addr", 32'(bus.mem_rd_addr), 32'(BASE));
    check("rst_busy", 32'(bus.frame_busy), 32'd0);
    check("rst_uf", 32'(bus.underflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic fetch: one ack, four bursts, then stall with the FIFO full.
    b0 = burst_log.size(); a0 = ack_total;
    do_req();
    repeat (2) @(negedge clk);
    check("basic_ack_once", 32'(ack_total - a0), 32'd1);
    for (int c = 0; c < 1500 && !((burst_log.size() - b0) >= 4 && !in_burst); c++) @(negedge clk);
    repeat (80) @(negedge clk);
    check("basic_bursts", 32'(burst_log.size() - b0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("basic_addr", 32'(burst_log[b0 + i]), 32'(BASE) + 32'(16 * i));
    check("basic_stall_req", 32'(bus.mem_rd_req), 32'd0);
    check("basic_busy", 32'(bus.frame_busy), 32'd1);

    // Full frame: fast memory, steady read_en from a full FIFO.
    gap_max = 0; ackd_max = 0;
    bus.read_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      check("frame_pix", 32'(bus.read_data), 32'(BASE) + 32'(k));
    end
    @(negedge clk);
    bus.read_en = 1'b0;
    wait_idle(300);
    check("frame_bursts", 32'(burst_log.size() - b0), 32'd16);
    check("frame_last_addr", 32'(burst_log[b0 + 15]), 32'(BASE) + 32'h0F0);
    check("frame_uf", 32'(bus.underflow), 32'd0);

    // Random frame: random memory timing and random pops against a model.
    gap_max = 3; ackd_max = 3;
    do_req();
    exp_rd = 16'h10FF; exp_uf = 1'b0; cnt = 0; popped = 0; exp_ucnt = 0;
    for (int c = 0; c < 6000 && popped < 256; c++) begin
      re = ($urandom_range(99, 0) < 45);
      bus.read_en = re;
      @(posedge clk);
      wr = bus.mem_rd_valid;
      if (re) begin
        if (cnt > 0) begin
          exp_rd = 16'(BASE) + 16'(popped);
          popped++;
          cnt--;
        end else begin
          exp_rd = '0;
          exp_uf = 1'b1;
          exp_ucnt++;
        end
      end
      if (wr) cnt++;
      #1;
      check("rand_data", 32'(bus.read_data), 32'(exp_rd));
      check("rand_uf", 32'(bus.underflow), 32'(exp_uf));
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
      check("rand_ucnt", 32'(bus.underflow_cnt), 32'(exp_ucnt));
`endif
      @(negedge clk);
    end
    bus.read_en = 1'b0;
    check("rand_pops_done", 32'(popped), 32'd256);
    wait_idle(300);
    pop_empty("uf_empty");
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("uf_cnt", 32'(bus.underflow_cnt), 32'(exp_ucnt + 1));
`endif

    // Restart on beat 5 of the burst at 0x1020.
    b0 = burst_log.size(); a0 = ack_total;
    do_req();
    check("restart_uf_cleared", 32'(bus.underflow), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk); #2;
      found = hit5;
    end
    check("restart_point", 32'(found), 32'd1);
    bus.read_req = 1'b1;
    wait_ack(500);
    check("restart_burst_done", 32'(beats_this_burst), 32'd16);
    check("restart_burst_addr", 32'(cur_addr), 32'h001020);
    check("restart_nbursts", 32'(burst_log.size() - b0), 32'd3);
    @(negedge clk);
    pop_empty("restart_fifo_empty");
    check("restart_acks", 32'(ack_total - a0), 32'd2);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("restart_ucnt", 32'(bus.underflow_cnt), 32'd1);
`endif
    for (int c = 0; c < 500 && (burst_log.size() - b0) < 4; c++) @(negedge clk);
    check("restart_next_addr", 32'(burst_log[b0 + 3]), 32'(BASE));

    // Reset while a burst is being received.
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk); #2;
      found = in_burst && beats_this_burst >= 3 && beats_this_burst < 16;
    end
    check("mid_burst_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_ack", 32'(bus.read_req_ack), 32'd0);
    check("mrst_data", 32'(bus.read_data), 32'd0);
    check("mrst_memreq", 32'(bus.mem_rd_req), 32'd0);
    check("mrst_addr", 32'(bus.mem_rd_addr), 32'(BASE));
    check("mrst_busy", 32'(bus.frame_busy), 32'd0);
    check("mrst_uf", 32'(bus.underflow), 32'd0);
`ifdef FRAME_READ_UNDERFLOW_CNT_EN
    check("mrst_ucnt", 32'(bus.underflow_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_memreq", 32'(bus.mem_rd_req), 32'd0);
    pop_empty("post_rst_empty");

    // Held read_req: exactly one ack.
    a0 = ack_total;
    bus.read_req = 1'b1;
    repeat (10) @(negedge clk);
    bus.read_req = 1'b0;
    repeat (3) @(negedge clk);
    check("held_one_ack", 32'(ack_total - a0), 32'd1);
    check("held_busy", 32'(bus.frame_busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
